hub75_fb_arbiter: RTL

- Shares the single-port HUB75 frame buffer RAM between two requesters: the row readout engine (display side) and a frame writer (host/SPI/DMA side).
- Grants exclusive ownership with a req/gnt/rel handshake.
- Multiplexes address and write strobes onto the RAM, and returns read data to the readout engine.
- Readout normally has priority; a streak limit prevents the writer from starving.
- A watchdog reclaims the RAM from a stuck owner.

---
 rtl/hub75_fb_pkg.sv | 17 +
 rtl/hub75_fb_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/hub75_fb_pkg.sv
// hub75_fb_pkg: shared FSM/owner encodings and the req/gnt/rel handshake bundle for frame buffer arbiters
package hub75_fb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } fb_state_e;
  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } fb_owner_e;
  typedef struct packed {
    logic req;
    logic gnt;
    logic rel;
  } fb_hs_t;
endpackage

// File: rtl/hub75_fb_arbiter.sv
// hub75_fb_arbiter: req/gnt/rel arbiter sharing the HUB75 frame buffer RAM between readout and writer
module hub75_fb_arbiter
  import hub75_fb_pkg::*;
#(
  parameter int FB_AW         = 13,
  parameter int FB_DW         = 16,
  parameter int FB_MW         = 4,
  parameter int MAX_RD_STREAK = 4,
  parameter int TIMEOUT       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  output logic             rd_gnt,
  input  logic             rd_rel,
  input  logic [FB_AW-1:0] rd_addr,
  output logic [FB_DW-1:0] rd_data,
  input  logic             wr_req,
  output logic             wr_gnt,
  input  logic             wr_rel,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [FB_DW-1:0] wr_data,
  input  logic [FB_MW-1:0] wr_mask,
  input  logic             wr_ena,
  output logic [FB_AW-1:0] fb_addr,
  output logic [FB_DW-1:0] fb_wr_data,
  output logic [FB_MW-1:0] fb_wr_mask,
  output logic             fb_wr_ena,
  input  logic [FB_DW-1:0] fb_rd_data,
  output logic             busy,
  output logic             err_timeout
);
  fb_state_e  state_q, state_d;
  fb_owner_e  owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] wd_q, wd_d;
  logic        rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d, err_q, err_d;
  logic        idle, grant_now, wr_win, own_rel, wd_fire, own_wr;
  always_comb begin
    idle      = state_q == ST_IDLE;
    grant_now = idle & (rd_req | wr_req);
    wr_win    = wr_req & (~rd_req | (streak_q >= 4'(MAX_RD_STREAK)));
    own_rel   = (owner_q == OWN_WR) ? wr_rel : rd_rel;
    wd_fire   = (TIMEOUT > 0) && !idle && (wd_q == 16'(TIMEOUT - 1));
    state_d   = idle ? (grant_now ? ST_GRANT : ST_IDLE) : ((own_rel | wd_fire) ? ST_IDLE : ST_BUSY);
    owner_d   = grant_now ? (wr_win ? OWN_WR : OWN_RD) : owner_q;
    streak_d  = !grant_now ? streak_q : (wr_win | ~wr_req) ? 4'd0 : (&streak_q) ? streak_q : streak_q + 4'd1;
    wd_d      = idle ? 16'd0 : wd_q + 16'd1;
    rd_gnt_d  = grant_now & ~wr_win;
    wr_gnt_d  = grant_now & wr_win;
    err_d     = wd_fire;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_RD;
      streak_q <= '0;
      wd_q     <= '0;
      rd_gnt_q <= 1'b0;
      wr_gnt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      wd_q     <= wd_d;
      rd_gnt_q <= rd_gnt_d;
      wr_gnt_q <= wr_gnt_d;
      err_q    <= err_d;
    end
  end
  assign own_wr      = owner_q == OWN_WR;
  assign busy        = ~idle;
  assign rd_gnt      = rd_gnt_q;
  assign wr_gnt      = wr_gnt_q;
  assign err_timeout = err_q;
  assign rd_data     = fb_rd_data;
  assign fb_addr     = own_wr ? wr_addr : rd_addr;
  assign fb_wr_data  = own_wr ? wr_data : '0;
  assign fb_wr_mask  = own_wr ? wr_mask : '0;
  assign fb_wr_ena   = own_wr & wr_ena & busy;
endmodule
